// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data DRAM between the CPU (port 0) and a debug/loader port (port 1)
module dram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, we_q, we_d, take, pick_dbg, iss, rsp;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0] starve_q, starve_d;
  // arbitrate in IDLE, latch the winner's access, track consecutive CPU wins over a waiting debug port
  always_comb begin
    pick_dbg = dbg_req && (!cpu_req || starve_q == SMAX);
    take     = state_q == IDLE && (cpu_req || dbg_req);
    state_d  = take ? ISSUE : state_q == ISSUE ? RESP : IDLE;
    gnt_d    = take ? pick_dbg : gnt_q;
    we_d     = take ? (pick_dbg ? dbg_we : cpu_we) : we_q;
    addr_d   = take ? (pick_dbg ? dbg_addr : cpu_addr) : addr_q;
    wdata_d  = take ? (pick_dbg ? dbg_wdata : cpu_wdata) : wdata_q;
    starve_d = !take ? starve_q : (pick_dbg || !dbg_req) ? 4'd0 :
               starve_q == SMAX ? starve_q : starve_q + 4'd1;
  end
  // sequencer and latched access registers; reset aborts any access in flight
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end
  assign iss       = state_q == ISSUE;
  assign rsp       = state_q == RESP;
  assign mem_en    = iss;
  assign mem_we    = iss && we_q;
  assign mem_addr  = iss ? addr_q : '0;
  assign mem_wdata = iss ? wdata_q : '0;
  assign busy      = iss || rsp;
  assign gnt_id    = busy && gnt_q;
  assign cpu_ready = rsp && !gnt_q;
  assign dbg_ready = rsp && gnt_q;
  assign cpu_rdata = cpu_ready && !we_q ? mem_rdata : '0;
  assign dbg_rdata = dbg_ready && !we_q ? mem_rdata : '0;
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port data DRAM between two requesters: the CPU data port (port 0) and a debug/loader port (port 1).
- The debug/loader port is used by bench and loader logic to preload or inspect memory at runtime.
- Sits between the CPU load/store path and the DRAM instance inside the SoC top.
- Fixed CPU priority with an anti-starvation counter for the debug port; one outstanding access at a time; 3-state sequencer.

Parameters:
- ADDR_W, 32, address width of both ports and of the memory side.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive CPU grants made while dbg_req is high before the debug port is forced a grant; legal range 1..15.

Ports:
- clk_in  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid only while cpu_ready = 1, otherwise 0.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ready, dbg_rdata: same directions, widths and meaning for the debug port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; synchronous, valid the cycle after mem_en.
- busy  out  1  high in ISSUE and RESP.
- gnt_id  out  1  port currently owning the memory (0 = CPU); 0 in IDLE.

Behaviour:
- Reset: state = IDLE; starve_cnt = 0; all outputs 0. Reset mid-operation aborts the access in flight: no ready pulse, mem_en drops next cycle, and requesters reissue.
- State IDLE: arbitrate on the current req inputs.
  - Neither req: stay in IDLE.
  - Only one req: grant that port.
  - Both req: grant dbg if starve_cnt == STARVE_MAX, else grant cpu.
  - On a grant: latch gnt, we, addr and wdata of the winner, then go to ISSUE.
- starve_cnt update at each grant:
  - dbg granted, or dbg_req low: starve_cnt <= 0.
  - cpu granted while dbg_req high: starve_cnt <= starve_cnt + 1, saturating at STARVE_MAX.
- State ISSUE (exactly 1 cycle): mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched registers; go to RESP.
- State RESP (exactly 1 cycle):
  - mem_en = 0.
  - ready of the granted port = 1; the other port's ready stays 0.
  - For reads, rdata of the granted port = mem_rdata. For writes, rdata = 0.
  - Go to IDLE.
- Timing:
  - Request sampled in cycle N → mem_en in N+1 → ready in N+2.
  - Peak throughput is 1 access per 3 cycles.
- mem_* outputs are 0 outside ISSUE. Address and data are driven only from latched values; input changes after the grant are ignored.
- Requester rule: req stays high until ready. req still high in the cycle after ready (IDLE) is a new request.
- A req deasserted before the grant is simply not served. A req dropped after the grant does not cancel the access; ready still pulses.
- No address alignment checks and no byte enables. The CPU issues word accesses only.

Test Plan:
- CPU read: preload mem[0x10] = 0xDEADBEEF; cpu_req with cpu_addr = 0x10 at cycle N → mem_en = 1 and mem_addr = 0x10 at N+1; cpu_ready = 1 and cpu_rdata = 0xDEADBEEF at N+2; dbg_ready stays 0.
- Debug write then CPU read: dbg write 0x12345678 to 0x20; then cpu read of 0x20 → mem_we = 1 only in dbg's ISSUE cycle; cpu_rdata = 0x12345678; gnt_id = 1, then 0.
- Simultaneous requests: both req at N → CPU granted, gnt_id = 0; dbg waits and is granted in the next IDLE (CPU req low) with dbg_ready at N+5.
- Starvation, STARVE_MAX = 4: CPU re-requests every IDLE while dbg_req is held high → exactly 4 CPU completions, then the 5th grant goes to dbg; starve_cnt returns to 0; the next grant goes to CPU.
- Reset mid-operation: reset asserted in the ISSUE cycle → next cycle all outputs 0 and state IDLE; no ready pulse; the reissued request completes normally.
- Idle hygiene: no req for 20 cycles → mem_en, busy, gnt_id and both ready signals stay 0; mem_addr and mem_wdata stay 0.
